// File: rtl/framebuffer_reader_unpacker_if.sv
// Stream interface shared by the memory-read side and the pixel side of the
// framebuffer reader.
//   tvalid/tready : handshake, transfer when both are high
//   tdata         : payload, DW bits
//   tkeep         : byte keep mask, DW/8 bits
//   tlast         : end-of-line marker
// modport master drives the payload, modport slave drives tready.
interface framebuffer_reader_unpacker_if #(
    parameter int DW = 128
) ();
    localparam int KW = DW / 8;

    logic          tvalid;
    logic          tready;
    logic [DW-1:0] tdata;
    logic [KW-1:0] tkeep;
    logic          tlast;

    modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);
endinterface

// File: rtl/framebuffer_reader_unpacker.sv
// Framebuffer read-side unpacker: takes wide memory beats with a byte keep
// mask and emits one pixel per cycle in ascending lane order, skipping lanes
// that are not fully kept.
//   aclk, resetn      : clock, asynchronous active-low reset
//   s_axis (slave)    : memory beats, DATA_WIDTH data, DATA_WIDTH/8 keep
//   m_axis (master)   : pixels, PIXEL_WIDTH data, tkeep all-ones while valid
//   m_lane            : source lane of the pixel on m_axis
//   err_dropped_last  : sticky, a tlast beat carried no valid lane
//   err_partial_lane  : sticky, a lane had mixed keep bits
//
// state  | meaning
// EMPTY  | no buffered word, ready for a new beat
// UNPACK | word buffered, a pixel is presented on m_axis
module framebuffer_reader_unpacker #(
    parameter  int DATA_WIDTH  = 128,
    parameter  int PIXEL_WIDTH = 32,
    localparam int LANE_COUNT  = DATA_WIDTH / PIXEL_WIDTH,
    localparam int LANE_BYTES  = PIXEL_WIDTH / 8,
    localparam int INDEX_WIDTH = (LANE_COUNT > 1) ? $clog2(LANE_COUNT) : 1
) (
    input  logic                         aclk,
    input  logic                         resetn,
    framebuffer_reader_unpacker_if.slave  s_axis,
    framebuffer_reader_unpacker_if.master m_axis,
    output logic [INDEX_WIDTH-1:0]       m_lane,
    output logic                         err_dropped_last,
    output logic                         err_partial_lane
);

    typedef enum logic {EMPTY, UNPACK} state_t;

    state_t                  state;
    logic                    run;
    logic [DATA_WIDTH-1:0]   word;
    logic                    word_last;
    logic [LANE_COUNT-1:0]   rem;        // lanes still to emit, excluding the one presented
    logic                    out_valid;
    logic [PIXEL_WIDTH-1:0]  out_data;
    logic                    out_last;

    logic [LANE_COUNT-1:0]   in_mask;
    logic                    in_partial;
    logic [INDEX_WIDTH-1:0]  in_idx;
    logic [LANE_COUNT-1:0]   in_rem;
    logic [PIXEL_WIDTH-1:0]  in_pix;
    logic [INDEX_WIDTH-1:0]  rem_idx;
    logic [LANE_COUNT-1:0]   rem_next;
    logic [PIXEL_WIDTH-1:0]  rem_pix;
    logic                    s_ready;
    logic                    accept;
    logic                    load;
    logic                    m_hs;

    function automatic logic [INDEX_WIDTH-1:0] lowest(input logic [LANE_COUNT-1:0] m);
        lowest = '0;
        for (int i = LANE_COUNT - 1; i >= 0; i--)
            if (m[i]) lowest = INDEX_WIDTH'(i);
    endfunction

    function automatic logic [LANE_COUNT-1:0] onehot(input logic [INDEX_WIDTH-1:0] idx);
        onehot = LANE_COUNT'(1) << idx;
    endfunction

    function automatic logic [PIXEL_WIDTH-1:0] lane_of(input logic [DATA_WIDTH-1:0] w,
                                                        input logic [INDEX_WIDTH-1:0] idx);
        lane_of = '0;
        for (int i = 0; i < LANE_COUNT; i++)
            if (INDEX_WIDTH'(i) == idx) lane_of = w[i*PIXEL_WIDTH +: PIXEL_WIDTH];
    endfunction

    always_comb begin
        in_mask    = '0;
        in_partial = 1'b0;
        for (int i = 0; i < LANE_COUNT; i++) begin
            in_mask[i] = &s_axis.tkeep[i*LANE_BYTES +: LANE_BYTES];
            if ((|s_axis.tkeep[i*LANE_BYTES +: LANE_BYTES]) && !in_mask[i])
                in_partial = 1'b1;
        end
        in_idx   = lowest(in_mask);
        in_rem   = in_mask & ~onehot(in_idx);
        in_pix   = lane_of(s_axis.tdata, in_idx);
        rem_idx  = lowest(rem);
        rem_next = rem & ~onehot(rem_idx);
        rem_pix  = lane_of(word, rem_idx);
    end

    // run keeps tready low while reset is held and for the release cycle.
    assign m_hs    = out_valid && m_axis.tready;
    assign s_ready = run && ((state == EMPTY) || (m_hs && (rem == '0)));
    assign accept  = s_axis.tvalid && s_ready;
    assign load    = accept && (in_mask != '0);

    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = out_valid;
    assign m_axis.tdata  = out_data;
    assign m_axis.tlast  = out_last;
    assign m_axis.tkeep  = {(PIXEL_WIDTH/8){out_valid}};

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state            <= EMPTY;
            run              <= 1'b0;
            word             <= '0;
            word_last        <= 1'b0;
            rem              <= '0;
            out_valid        <= 1'b0;
            out_data         <= '0;
            out_last         <= 1'b0;
            m_lane           <= '0;
            err_dropped_last <= 1'b0;
            err_partial_lane <= 1'b0;
        end else begin
            run <= 1'b1;
            if (accept) begin
                if (in_partial) err_partial_lane <= 1'b1;
                if ((in_mask == '0) && s_axis.tlast) err_dropped_last <= 1'b1;
            end
            if (load) begin
                state     <= UNPACK;
                word      <= s_axis.tdata;
                word_last <= s_axis.tlast;
                rem       <= in_rem;
                out_valid <= 1'b1;
                out_data  <= in_pix;
                out_last  <= s_axis.tlast && (in_rem == '0);
                m_lane    <= in_idx;
            end else if ((state == UNPACK) && m_hs) begin
                if (rem != '0) begin
                    rem      <= rem_next;
                    out_data <= rem_pix;
                    out_last <= word_last && (rem_next == '0);
                    m_lane   <= rem_idx;
                end else begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_framebuffer_reader_unpacker.sv
module tb_framebuffer_reader_unpacker;
    localparam int DW = 128;
    localparam int PW = 32;

    logic aclk = 1'b0;
    logic resetn = 1'b0;
    always #5 aclk = ~aclk;

    framebuffer_reader_unpacker_if #(.DW(DW)) s_if ();
    framebuffer_reader_unpacker_if #(.DW(PW)) m_if ();
    logic [1:0] m_lane;
    logic       err_d;
    logic       err_p;

    framebuffer_reader_unpacker #(.DATA_WIDTH(DW), .PIXEL_WIDTH(PW)) dut (
        .aclk             (aclk),
        .resetn           (resetn),
        .s_axis           (s_if),
        .m_axis           (m_if),
        .m_lane           (m_lane),
        .err_dropped_last (err_d),
        .err_partial_lane (err_p)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] pq_data[$];
    int          pq_lane[$];
    logic        pq_last[$];
    int          pq_edge[$];
    logic        pq_sready[$];
    int          acc_edge[$];

    localparam logic [127:0] B1 = {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
    localparam logic [127:0] B2 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

    always @(posedge aclk) cyc <= cyc + 1;

    // Record handshakes at the falling edge; they complete on the next rising edge.
    always @(negedge aclk) begin
        if (resetn) begin
            if (s_if.tvalid && s_if.tready) acc_edge.push_back(cyc + 1);
            if (m_if.tvalid && m_if.tready) begin
                pq_data.push_back(m_if.tdata);
                pq_lane.push_back(int'(m_lane));
                pq_last.push_back(m_if.tlast);
                pq_edge.push_back(cyc + 1);
                pq_sready.push_back(s_if.tready);
            end
        end
    end

    function automatic logic [31:0] px(input logic [127:0] b, input int i);
        return b[i*32 +: 32];
    endfunction

    task automatic clear_q();
        pq_data.delete(); pq_lane.delete(); pq_last.delete();
        pq_edge.delete(); pq_sready.delete(); acc_edge.delete();
    endtask

    task automatic send_beat(input logic [127:0] d, input logic [15:0] k, input logic l);
        int n;
        s_if.tdata = d; s_if.tkeep = k; s_if.tlast = l; s_if.tvalid = 1'b1;
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (!s_if.tready && n < 50);
        if (!s_if.tready) begin
            checks++; failures++;
            $display("FAIL send_beat_timeout tready=%b required 1", s_if.tready);
        end
        @(posedge aclk); #1;
        s_if.tvalid = 1'b0;
    endtask

    task automatic wait_pix(input int n, output bit ok);
        int c;
        c = 0;
        while (pq_data.size() < n && c < 60) begin
            @(posedge aclk); #1;
            c++;
        end
        ok = (pq_data.size() >= n);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge aclk);
        #1;
        checks++;
        if ({m_if.tvalid, m_if.tlast, s_if.tready, err_d, err_p} !== 5'b0 || m_if.tdata !== 32'h0 || m_lane !== 2'd0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b l=%b sr=%b ed=%b ep=%b d=%h lane=%0d required all 0",
                     m_if.tvalid, m_if.tlast, s_if.tready, err_d, err_p, m_if.tdata, m_lane);
        end
        resetn = 1'b1;
        @(posedge aclk); #1;
        checks++;
        if (s_if.tready !== 1'b1 || m_if.tvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got sready=%b mvalid=%b required 1 0", s_if.tready, m_if.tvalid);
        end
    endtask

    task automatic test_full_beat();
        bit ok;
        clear_q();
        m_if.tready = 1'b1;
        send_beat(B1, 16'hFFFF, 1'b1);
        wait_pix(4, ok);
        repeat (3) @(posedge aclk);
        #1;
        checks++;
        if (pq_data.size() != 4 || acc_edge.size() != 1) begin
            failures++;
            $display("FAIL full_count got px=%0d acc=%0d required 4 1", pq_data.size(), acc_edge.size());
        end
        for (int i = 0; i < pq_data.size() && i < 4 && acc_edge.size() > 0; i++) begin
            checks++;
            if (pq_data[i] !== px(B1, i) || pq_lane[i] != i || pq_last[i] !== (i == 3) || pq_edge[i] != acc_edge[0] + 1 + i) begin
                failures++;
                $display("FAIL full_px%0d got d=%h lane=%0d last=%b edge=%0d required d=%h lane=%0d last=%b edge=%0d",
                         i, pq_data[i], pq_lane[i], pq_last[i], pq_edge[i], px(B1, i), i, (i == 3), acc_edge[0] + 1 + i);
            end
        end
    endtask

    task automatic test_sparse_lanes();
        bit ok;
        clear_q();
        send_beat(B1, 16'hF0F0, 1'b0);
        wait_pix(2, ok);
        repeat (3) @(posedge aclk);
        #1;
        checks++;
        if (pq_data.size() != 2) begin
            failures++;
            $display("FAIL sparse_count got %0d required 2", pq_data.size());
        end else begin
            checks++;
            if (pq_lane[0] != 1 || pq_lane[1] != 3 || pq_data[0] !== px(B1, 1) || pq_data[1] !== px(B1, 3)) begin
                failures++;
                $display("FAIL sparse_lanes got %0d:%h %0d:%h required 1:%h 3:%h",
                         pq_lane[0], pq_data[0], pq_lane[1], pq_data[1], px(B1, 1), px(B1, 3));
            end
            checks++;
            if (pq_last[0] !== 1'b0 || pq_last[1] !== 1'b0 || pq_sready[0] !== 1'b0 || pq_sready[1] !== 1'b1) begin
                failures++;
                $display("FAIL sparse_last_ready got last=%b%b sready=%b%b required 00 01",
                         pq_last[0], pq_last[1], pq_sready[0], pq_sready[1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_q();
        send_beat(B1, 16'hFFFF, 1'b0);
        send_beat(B2, 16'hFFFF, 1'b1);
        wait_pix(8, ok);
        repeat (3) @(posedge aclk);
        #1;
        checks++;
        if (pq_data.size() != 8 || acc_edge.size() != 2) begin
            failures++;
            $display("FAIL b2b_count got px=%0d acc=%0d required 8 2", pq_data.size(), acc_edge.size());
        end else begin
            checks++;
            if (acc_edge[1] != acc_edge[0] + 4) begin
                failures++;
                $display("FAIL b2b_accept_gap got %0d required %0d", acc_edge[1], acc_edge[0] + 4);
            end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (pq_data[i] !== px((i < 4) ? B1 : B2, i % 4) || pq_edge[i] != acc_edge[0] + 1 + i ||
                    pq_sready[i] !== (i % 4 == 3) || pq_last[i] !== (i == 7)) begin
                    failures++;
                    $display("FAIL b2b_px%0d got d=%h edge=%0d sr=%b last=%b required d=%h edge=%0d sr=%b last=%b",
                             i, pq_data[i], pq_edge[i], pq_sready[i], pq_last[i],
                             px((i < 4) ? B1 : B2, i % 4), acc_edge[0] + 1 + i, (i % 4 == 3), (i == 7));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        clear_q();
        send_beat(B2, 16'hFFFF, 1'b1);
        @(posedge aclk); #1;
        m_if.tready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (m_if.tvalid !== 1'b1 || m_if.tdata !== px(B2, 1) || m_lane !== 2'd1 || m_if.tlast !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold%0d got v=%b d=%h lane=%0d last=%b required 1 %h 1 0",
                         c, m_if.tvalid, m_if.tdata, m_lane, m_if.tlast, px(B2, 1));
            end
            @(posedge aclk); #1;
        end
        m_if.tready = 1'b1;
        wait_pix(4, ok);
        repeat (3) @(posedge aclk);
        #1;
        checks++;
        if (pq_data.size() != 4) begin
            failures++;
            $display("FAIL stall_count got %0d required 4", pq_data.size());
        end
        for (int i = 0; i < pq_data.size() && i < 4; i++) begin
            checks++;
            if (pq_data[i] !== px(B2, i) || pq_lane[i] != i || pq_last[i] !== (i == 3)) begin
                failures++;
                $display("FAIL stall_px%0d got d=%h lane=%0d last=%b required %h %0d %b",
                         i, pq_data[i], pq_lane[i], pq_last[i], px(B2, i), i, (i == 3));
            end
        end
    endtask

    task automatic test_errors();
        bit ok;
        clear_q();
        send_beat(B1, 16'h0000, 1'b1);
        repeat (3) @(posedge aclk);
        #1;
        checks++;
        if (pq_data.size() != 0 || acc_edge.size() != 1 || err_d !== 1'b1 || err_p !== 1'b0) begin
            failures++;
            $display("FAIL drop_last got px=%0d acc=%0d ed=%b ep=%b required 0 1 1 0",
                     pq_data.size(), acc_edge.size(), err_d, err_p);
        end
        send_beat(B1, 16'h00F8, 1'b0);
        wait_pix(1, ok);
        repeat (3) @(posedge aclk);
        #1;
        checks++;
        if (pq_data.size() != 1 || err_p !== 1'b1 || err_d !== 1'b1) begin
            failures++;
            $display("FAIL partial_flags got px=%0d ep=%b ed=%b required 1 1 1", pq_data.size(), err_p, err_d);
        end else begin
            checks++;
            if (pq_data[0] !== px(B1, 1) || pq_lane[0] != 1 || pq_last[0] !== 1'b0) begin
                failures++;
                $display("FAIL partial_px got d=%h lane=%0d last=%b required %h 1 0",
                         pq_data[0], pq_lane[0], pq_last[0], px(B1, 1));
            end
        end
    endtask

    task automatic test_reset_midword();
        bit ok;
        clear_q();
        send_beat(B2, 16'hFFFF, 1'b0);
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        checks++;
        if (pq_data.size() != 2) begin
            failures++;
            $display("FAIL midreset_pre got %0d required 2", pq_data.size());
        end
        resetn = 1'b0;
        #1;
        checks++;
        if ({m_if.tvalid, m_if.tlast, s_if.tready, err_d, err_p} !== 5'b0 || m_if.tdata !== 32'h0 || m_lane !== 2'd0) begin
            failures++;
            $display("FAIL midreset_outputs got v=%b l=%b sr=%b ed=%b ep=%b d=%h lane=%0d required all 0",
                     m_if.tvalid, m_if.tlast, s_if.tready, err_d, err_p, m_if.tdata, m_lane);
        end
        repeat (2) @(posedge aclk);
        #1;
        clear_q();
        resetn = 1'b1;
        @(posedge aclk); #1;
        send_beat(B1, 16'hFFFF, 1'b1);
        wait_pix(4, ok);
        repeat (4) @(posedge aclk);
        #1;
        checks++;
        if (pq_data.size() != 4 || err_d !== 1'b0 || err_p !== 1'b0) begin
            failures++;
            $display("FAIL midreset_post got px=%0d ed=%b ep=%b required 4 0 0", pq_data.size(), err_d, err_p);
        end
        for (int i = 0; i < pq_data.size() && i < 4; i++) begin
            checks++;
            if (pq_data[i] !== px(B1, i) || pq_lane[i] != i) begin
                failures++;
                $display("FAIL midreset_px%0d got d=%h lane=%0d required %h %0d",
                         i, pq_data[i], pq_lane[i], px(B1, i), i);
            end
        end
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;
        test_reset();
        test_full_beat();
        test_sparse_lanes();
        test_back_to_back();
        test_backpressure();
        test_errors();
        test_reset_midword();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/framebuffer_reader_unpacker.md
Name: framebuffer_reader_unpacker

Overview:
- Read-side counterpart of the framebuffer write-strobe path.
- Accepts wide memory read beats carrying a byte keep mask, and serialises them into one pixel per cycle in lane order.
- Lanes whose keep bytes are not all set are skipped.
- Sits between the memory read stream and the display/readback pixel consumers.

Parameters:
- DATA_WIDTH, 128, memory beat width in bits.
- PIXEL_WIDTH, 32, pixel width in bits; must be a multiple of 8 and divide DATA_WIDTH.
- (derived) LANE_COUNT = DATA_WIDTH/PIXEL_WIDTH; LANE_BYTES = PIXEL_WIDTH/8; INDEX_WIDTH = max(1, $clog2(LANE_COUNT)).

Ports:
- aclk  input  1  clock, all logic on rising edge.
- resetn  input  1  asynchronous active-low reset.
- s_axis_tvalid  input  1  memory beat valid.
- s_axis_tready  output  1  beat accepted when valid&&ready.
- s_axis_tdata  input  DATA_WIDTH  beat data; lane i = bits [i*PIXEL_WIDTH +: PIXEL_WIDTH].
- s_axis_tkeep  input  DATA_WIDTH/8  byte keep mask.
- s_axis_tlast  input  1  last beat of a line.
- m_axis_tvalid  output  1  pixel valid.
- m_axis_tready  input  1  consumer ready.
- m_axis_tdata  output  PIXEL_WIDTH  pixel.
- m_axis_tlast  output  1  last pixel of a line.
- m_lane  output  INDEX_WIDTH  source lane index of the current pixel.
- err_dropped_last  output  1  sticky: a tlast beat had no valid lanes.
- err_partial_lane  output  1  sticky: a lane had mixed keep bits.

Behaviour:
- Reset (async assert, sync release): all outputs 0; word buffer empty; lane mask cleared; sticky errors cleared. Reset mid-word discards the buffered word and any pending pixel.
- Lane valid mask: lane i is valid only if all LANE_BYTES keep bits of lane i are 1.
- Mixed keep in a lane (some bytes set, not all): the lane is skipped and err_partial_lane is set. It stays set until reset.
- Two states:
  - EMPTY: s_axis_tready=1.
  - UNPACK: holds the buffered word plus its remaining-lane mask.
- On accept, the remaining-lane mask is loaded from the lane valid mask.
  - Mask nonzero: go to UNPACK. The first pixel appears on m_axis_* in the next cycle (latency 1).
  - Mask zero: the word is consumed with no output and the state stays EMPTY. If that beat had tlast=1, set err_dropped_last; the tlast is lost.
- UNPACK: output register holds the lowest-index remaining lane. Set m_lane to that index. Set m_axis_tlast = buffered tlast && this is the last remaining lane.
- On each m_axis_tvalid&&m_axis_tready, clear that lane and present the next lowest remaining lane in the next cycle.
- Throughput: s_axis_tready = EMPTY || (m_axis_tvalid && m_axis_tready && current lane is the last remaining). This gives back-to-back words with no bubble: one pixel per cycle sustained.
  - If the word accepted in that same cycle has a nonzero mask, its first pixel is valid next cycle.
  - Otherwise go to EMPTY.
- Backpressure: while m_axis_tvalid && !m_axis_tready, m_axis_tdata, m_axis_tlast and m_lane are held stable. m_axis_tvalid never deasserts without a handshake.
- s_axis_tready is not combinationally dependent on s_axis_tvalid.

Test Plan:
1. Full beat, tkeep=16'hFFFF, tdata lanes {D,C,B,A}, tlast=1, m_tready=1 -> pixels A,B,C,D on 4 consecutive cycles starting 1 cycle after accept; m_lane 0..3; tlast only with D.
2. tkeep=16'hF0F0 (lanes 1,3), tlast=0 -> exactly 2 pixels, lanes 1 then 3; m_axis_tlast=0; s_axis_tready rises in the cycle the lane-3 handshake occurs.
3. Back-to-back full beats, m_tready=1 constantly -> 8 pixels in 8 consecutive cycles; no tvalid gap; s_axis_tready pulses once per 4 cycles.
4. m_tready held 0 for 5 cycles mid-word -> data, m_lane and tlast held constant; no pixel lost or duplicated after release.
5. tkeep=0 with tlast=1, then tkeep=16'h00F8 -> first beat produces no output and err_dropped_last=1. Second beat emits lane 1 only and sets err_partial_lane=1 (lane 0 mixed).
6. Assert resetn=0 mid-word after 2 pixels, release, send a new full beat -> outputs 0 during reset; errors cleared; only the new beat's 4 pixels appear.
